rx_lane_aligner: RTL

Deskews the per-lane byte streams produced by the per-lane rx_byte_aligner instances, one per D-PHY data lane. Each lane's byte aligner asserts its valid independently, up to MAX_SKEW clocks apart. This block measures the arrival skew once per packet and delays early lanes so that all lanes present their sync-aligned first byte on the same cycle. It feeds the packet/header decoder with a lane-coherent word plus one valid.

---
 rtl/rx_csi_pkg.sv | 17 +
 rtl/rx_lane_aligner_if.sv | 30 +++
 rtl/rx_lane_delay.sv | 60 ++++++
 rtl/rx_lane_aligner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rx_csi_pkg.sv
// Shared definitions for the CSI receive path.
//   state_e   : lane aligner FSM encoding
//   MIPI_GEAR : bits per lane byte
//   MAX_LANES : widest supported D-PHY lane count
package rx_csi_pkg;

  localparam int MIPI_GEAR = 8;
  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ALL = 2'd1,
    ST_ALIGNED  = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

endpackage

// File: rtl/rx_lane_aligner_if.sv
// Bus between the per-lane byte aligners and the packet decoder.
//   bytes_valid_i : per-lane valid from the byte aligners
//   byte_i        : per-lane bytes, lane k at [8k+7:8k]
//   lane_bytes_o  : deskewed bytes, same packing
//   lane_valid_o  : all lanes of lane_bytes_o valid and aligned
//   skew_err_o    : one-cycle pulse on skew or dropout error
// master drives the lane streams, slave is the aligner.
interface rx_lane_aligner_if
  import rx_csi_pkg::*;
#(
  parameter int LANES = 4
);

  logic [LANES-1:0]           bytes_valid_i;
  logic [MIPI_GEAR*LANES-1:0] byte_i;
  logic [MIPI_GEAR*LANES-1:0] lane_bytes_o;
  logic                       lane_valid_o;
  logic                       skew_err_o;

  modport master (
    output bytes_valid_i, byte_i,
    input  lane_bytes_o, lane_valid_o, skew_err_o
  );

  modport slave (
    input  bytes_valid_i, byte_i,
    output lane_bytes_o, lane_valid_o, skew_err_o
  );

endinterface

// File: rtl/rx_lane_delay.sv
// Per-lane history shift register with a variable read tap.
//   clk_i, reset_i : byte clock, synchronous active-high reset
//   valid_i/byte_i : lane sample, shifted in every clock
//   delay_i        : tap select, 0 returns the most recent sample
//   valid_o/byte_o : sample taken delay_i clocks before the most recent one
module rx_lane_delay
  import rx_csi_pkg::*;
#(
  parameter int MAX_DELAY = 7
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [MIPI_GEAR-1:0] byte_i,
  input  logic [3:0]           delay_i,
  output logic                 valid_o,
  output logic [MIPI_GEAR-1:0] byte_o
);

  localparam int DEPTH = MAX_DELAY + 2;

  logic [MIPI_GEAR-1:0] byte_q  [DEPTH];
  logic [MIPI_GEAR-1:0] byte_d  [DEPTH];
  logic                 valid_q [DEPTH];
  logic                 valid_d [DEPTH];

  always_comb begin
    byte_d[0]  = byte_i;
    valid_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      byte_d[i]  = byte_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // Explicit compare mux keeps the tap in range whatever delay_i holds.
  always_comb begin
    byte_o  = byte_q[0];
    valid_o = valid_q[0];
    for (int i = 1; i <= MAX_DELAY; i++) begin
      if (delay_i == 4'(i)) begin
        byte_o  = byte_q[i];
        valid_o = valid_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        byte_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rx_lane_aligner.sv
// Multi-lane deskew: measures per-packet lane arrival skew and delays
// early lanes so every lane's first byte leaves on the same cycle.
//   clk_i, reset_i : byte clock, synchronous active-high reset
//   bus (slave)    : lane streams in, lane-coherent word + valid out,
//                    skew/dropout error pulse
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | no packet; waiting for any lane valid
// WAIT_ALL | some lanes started; stamping arrivals, cnt running
// ALIGNED  | delays latched; emitting deskewed words
// ERROR    | skew limit or dropout; waiting for all lanes to go low
module rx_lane_aligner
  import rx_csi_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int MAX_SKEW = 7
) (
  input logic              clk_i,
  input logic              reset_i,
  rx_lane_aligner_if.slave bus
);

  localparam logic [3:0] SKEW_LIM = 4'(MAX_SKEW);

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [LANES-1:0]           got_q, got_d;
  logic [3:0]                 stamp_q [LANES];
  logic [3:0]                 stamp_d [LANES];
  logic [3:0]                 delay_q [LANES];
  logic [3:0]                 delay_d [LANES];
  logic [MIPI_GEAR*LANES-1:0] lane_bytes_q, lane_bytes_d;
  logic                       lane_valid_q, lane_valid_d;
  logic                       skew_err_q, skew_err_d;
  logic                       dead_q, dead_d;

  logic [MIPI_GEAR-1:0]       tap_byte [LANES];
  logic [LANES-1:0]           tap_valid;
  logic [LANES-1:0]           vld;
  logic                       all_hi, any_hi, dropout, all_tap;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rx_lane_delay #(.MAX_DELAY(MAX_SKEW)) u_delay (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (bus.bytes_valid_i[k]),
      .byte_i  (bus.byte_i[MIPI_GEAR*k +: MIPI_GEAR]),
      .delay_i (delay_q[k]),
      .valid_o (tap_valid[k]),
      .byte_o  (tap_byte[k])
    );
  end

  assign vld     = bus.bytes_valid_i;
  assign all_hi  = &vld;
  assign any_hi  = |vld;
  assign dropout = |(got_q & ~vld);
  assign all_tap = &tap_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    got_d        = got_q;
    stamp_d      = stamp_q;
    delay_d      = delay_q;
    lane_bytes_d = lane_bytes_q;
    lane_valid_d = 1'b0;
    skew_err_d   = 1'b0;
    dead_d       = dead_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        dead_d = 1'b0;
        got_d  = vld;
        for (int k = 0; k < LANES; k++) begin
          stamp_d[k] = '0;
          delay_d[k] = '0;
        end
        if (all_hi) begin
          state_d = ST_ALIGNED;
        end else if (any_hi) begin
          state_d = ST_WAIT_ALL;
          cnt_d   = 4'd1;
        end
      end

      ST_WAIT_ALL: begin
        cnt_d = cnt_q + 4'd1;
        got_d = got_q | vld;
        for (int k = 0; k < LANES; k++) begin
          if (vld[k] && !got_q[k]) stamp_d[k] = cnt_q;
        end
        if (dropout) begin
          state_d    = ST_ERROR;
          skew_err_d = 1'b1;
        end else if (all_hi) begin
          // Lanes arriving on this edge were stamped with cnt_q, so they get 0.
          for (int k = 0; k < LANES; k++) delay_d[k] = cnt_q - stamp_d[k];
          state_d = ST_ALIGNED;
        end else if (cnt_q == SKEW_LIM) begin
          state_d    = ST_ERROR;
          skew_err_d = 1'b1;
        end
      end

      ST_ALIGNED: begin
        // The exit edge still emits: it carries every lane's final byte.
        for (int k = 0; k < LANES; k++) begin
          lane_bytes_d[MIPI_GEAR*k +: MIPI_GEAR] = tap_byte[k];
        end
        lane_valid_d = all_tap & ~dead_q;
        dead_d       = dead_q | ~all_tap;
        if (!any_hi) state_d = ST_IDLE;
      end

      ST_ERROR: begin
        if (!any_hi) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      got_q        <= '0;
      lane_bytes_q <= '0;
      lane_valid_q <= 1'b0;
      skew_err_q   <= 1'b0;
      dead_q       <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        stamp_q[k] <= '0;
        delay_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      got_q        <= got_d;
      stamp_q      <= stamp_d;
      delay_q      <= delay_d;
      lane_bytes_q <= lane_bytes_d;
      lane_valid_q <= lane_valid_d;
      skew_err_q   <= skew_err_d;
      dead_q       <= dead_d;
    end
  end

  assign bus.lane_bytes_o = lane_bytes_q;
  assign bus.lane_valid_o = lane_valid_q;
  assign bus.skew_err_o   = skew_err_q;

endmodule
